// File: rtl/nec_ir_rx_if.sv
// Decoded-frame output bundle of the NEC IR receiver.
// The receiver drives it; the display driver consumes it.
interface nec_ir_rx_if;
  logic [19:0] data;
  logic [7:0]  ir_addr;
  logic        seg_en;
  logic        data_valid;
  logic        repeat_en;
  logic        frame_err;

  modport master (output data, ir_addr, seg_en, data_valid, repeat_en, frame_err);
  modport slave  (input  data, ir_addr, seg_en, data_valid, repeat_en, frame_err);
endinterface

// File: rtl/nec_ir_rx.sv
// NEC IR frame receiver.
// Measures pulse widths, decodes 32-bit frames and repeat codes, and reports the command byte.
module nec_ir_rx #(
  parameter int unsigned LEAD_L_MIN = 400_000,
  parameter int unsigned LEAD_L_MAX = 500_000,
  parameter int unsigned LEAD_H_MIN = 200_000,
  parameter int unsigned LEAD_H_MAX = 250_000,
  parameter int unsigned RPT_H_MIN  = 100_000,
  parameter int unsigned RPT_H_MAX  = 125_000,
  parameter int unsigned BIT_S_MIN  = 20_000,
  parameter int unsigned BIT_S_MAX  = 35_000,
  parameter int unsigned BIT_L_MIN  = 75_000,
  parameter int unsigned BIT_L_MAX  = 95_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          infrared_in,
  nec_ir_rx_if.master   ir
);
  localparam logic [19:0] LL_MIN = 20'(LEAD_L_MIN);
  localparam logic [19:0] LL_MAX = 20'(LEAD_L_MAX);
  localparam logic [19:0] LH_MIN = 20'(LEAD_H_MIN);
  localparam logic [19:0] LH_MAX = 20'(LEAD_H_MAX);
  localparam logic [19:0] RH_MIN = 20'(RPT_H_MIN);
  localparam logic [19:0] RH_MAX = 20'(RPT_H_MAX);
  localparam logic [19:0] BS_MIN = 20'(BIT_S_MIN);
  localparam logic [19:0] BS_MAX = 20'(BIT_S_MAX);
  localparam logic [19:0] BL_MIN = 20'(BIT_L_MIN);
  localparam logic [19:0] BL_MAX = 20'(BIT_L_MAX);

  typedef enum logic [2:0] {IDLE, LEAD_L, LEAD_H, DATA_L, DATA_H, CHECK} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sync_pipe;
  logic [19:0] cnt;
  logic [31:0] sh;
  logic [4:0]  bit_cnt;
  logic        rpt_armed;
  logic        fall, rise;
  logic        abort, shift_en, bit_val, clr_frame, rpt_hit, chk_pass;
  logic        dv_nxt, rpt_nxt, err_nxt;

  function automatic logic in_win(input logic [19:0] v, input logic [19:0] lo, input logic [19:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Synchronizer stages reset low so a line already idle-high only yields an ignored rise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[1:0], infrared_in};
  end

  assign fall = sync_pipe[2] & ~sync_pipe[1];
  assign rise = ~sync_pipe[2] & sync_pipe[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst)          cnt <= '0;
    else if (fall | rise) cnt <= '0;
    else if (cnt != '1)   cnt <= cnt + 20'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    shift_en  = 1'b0;
    bit_val   = 1'b0;
    clr_frame = 1'b0;
    rpt_hit   = 1'b0;
    chk_pass  = 1'b0;
    case (state)
      IDLE:   if (fall) state_nxt = LEAD_L;
      LEAD_L: begin
        if (rise) begin
          if (in_win(cnt, LL_MIN, LL_MAX)) state_nxt = LEAD_H;
          else                             abort = 1'b1;
        end else if (cnt > LL_MAX) abort = 1'b1;
      end
      LEAD_H: begin
        if (fall) begin
          if (in_win(cnt, LH_MIN, LH_MAX)) begin
            clr_frame = 1'b1;
            state_nxt = DATA_L;
          end else if (in_win(cnt, RH_MIN, RH_MAX)) begin
            rpt_hit   = 1'b1;
            state_nxt = IDLE;
          end else abort = 1'b1;
        end else if (cnt > LH_MAX) abort = 1'b1;
      end
      DATA_L: begin
        if (rise) begin
          if (in_win(cnt, BS_MIN, BS_MAX)) state_nxt = DATA_H;
          else                             abort = 1'b1;
        end else if (cnt > BS_MAX) abort = 1'b1;
      end
      DATA_H: begin
        if (fall) begin
          if (in_win(cnt, BS_MIN, BS_MAX))      shift_en = 1'b1;
          else if (in_win(cnt, BL_MIN, BL_MAX)) begin
            shift_en = 1'b1;
            bit_val  = 1'b1;
          end else abort = 1'b1;
          if (shift_en) state_nxt = (bit_cnt == 5'd31) ? CHECK : DATA_L;
        end else if (cnt > BL_MAX) abort = 1'b1;
      end
      CHECK: begin
        chk_pass  = (sh[15:8] == ~sh[7:0]) && (sh[31:24] == ~sh[23:16]);
        abort     = ~chk_pass;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    dv_nxt  = (state == CHECK) && chk_pass;
    rpt_nxt = rpt_hit && rpt_armed;
    err_nxt = abort;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sh            <= '0;
      bit_cnt       <= '0;
      rpt_armed     <= 1'b0;
      ir.data       <= '0;
      ir.ir_addr    <= '0;
      ir.seg_en     <= 1'b0;
      ir.data_valid <= 1'b0;
      ir.repeat_en  <= 1'b0;
      ir.frame_err  <= 1'b0;
    end else begin
      ir.data_valid <= dv_nxt;
      ir.repeat_en  <= rpt_nxt;
      ir.frame_err  <= err_nxt;
      if (clr_frame) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        // LSB first on air: each new bit enters at the top and walks down
        sh      <= {bit_val, sh[31:1]};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (dv_nxt) begin
        ir.data    <= {12'd0, sh[23:16]};
        ir.ir_addr <= sh[7:0];
        ir.seg_en  <= 1'b1;
        rpt_armed  <= 1'b1;
      end else if (abort) begin
        rpt_armed  <= 1'b0;
      end
    end
  end
endmodule
